// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types for the command-to-AXI-Lite bridge: FSM state encoding and
// AXI response codes.
package axi_lite_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // States in which a bus phase is outstanding and the timeout runs.
    function automatic logic is_bus_phase(input state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
               (s == ST_RD_REQ) || (s == ST_RD_RESP);
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master_phase_timer.sv
// Per-phase cycle counter. i_clear marks the first cycle of a state, so the
// count seen in that cycle is 0; o_expired flags the terminal cycle.
module axi_lite_cmd_master_phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned  CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned  LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST  = LAST_I[CW-1:0];
    localparam logic          ACTIVE = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count;

    assign w_count   = i_clear ? '0 : r_count;
    assign o_expired = ACTIVE && i_enable && (w_count == LAST);

    // Saturates at the terminal value, so the counter can never wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (ACTIVE && i_enable && (w_count != LAST)) begin
            r_count <= w_count + 1'b1;
        end else begin
            r_count <= w_count;
        end
    end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding bridge from a register command stream to an AXI-Lite
// master port, returning data/response on a second stream.
module axi_lite_cmd_master
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_write,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,
    output logic                    o_arvalid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_arready,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output state_t                  o_dbg_state
);

    // Every stream here (cmd, rsp, AW, W, B, AR, R) transfers on a rising clock
    // edge where valid and ready are both high; a valid, once raised, holds with
    // stable payload until that edge (only a phase timeout may withdraw it).

    state_t                  r_state;
    logic                    r_state_entry;
    logic                    r_cmd_write;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic                    r_rsp_write;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;
    logic                    r_awvalid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_wvalid;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STROBE_WIDTH-1:0] r_wstrb;
    logic                    r_bready;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_rready;

    logic w_aw_done;
    logic w_w_done;
    logic w_phase_done;
    logic w_expired;
    logic w_abort;

    assign w_aw_done = r_aw_done | (r_awvalid & i_awready);
    assign w_w_done  = r_w_done  | (r_wvalid  & i_wready);

    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            ST_WR_REQ:  w_phase_done = w_aw_done & w_w_done;
            ST_WR_RESP: w_phase_done = i_bvalid;
            ST_RD_REQ:  w_phase_done = i_arready;
            ST_RD_RESP: w_phase_done = i_rvalid;
            default:    w_phase_done = 1'b0;
        endcase
    end

    axi_lite_cmd_master_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phase_timer (
        .i_clk     (i_axi_clk),
        .i_rst_n   (i_axi_rst),
        .i_clear   (r_state_entry),
        .i_enable  (is_bus_phase(r_state)),
        .o_expired (w_expired)
    );

    // A handshake landing on the terminal count completes the phase normally.
    assign w_abort = w_expired & ~w_phase_done;

    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            r_state       <= ST_IDLE;
            r_state_entry <= 1'b1;
            r_cmd_write   <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= '0;
            r_wvalid      <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_rready      <= 1'b0;
        end else begin
            r_state_entry <= 1'b0;
            if (w_abort) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_write   <= r_cmd_write;
                r_rsp_data    <= '0;
                r_rsp_resp    <= RESP_SLVERR;
                r_rsp_timeout <= 1'b1;
                r_state       <= ST_RSP;
                r_state_entry <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cmd_ready <= 1'b1;
                        if (i_cmd_valid && r_cmd_ready) begin
                            r_cmd_ready   <= 1'b0;
                            r_cmd_write   <= i_cmd_write;
                            r_aw_done     <= 1'b0;
                            r_w_done      <= 1'b0;
                            r_state_entry <= 1'b1;
                            if (i_cmd_write) begin
                                r_awvalid <= 1'b1;
                                r_awaddr  <= i_cmd_addr;
                                r_wvalid  <= 1'b1;
                                r_wdata   <= i_cmd_data;
                                r_wstrb   <= i_cmd_strb;
                                r_state   <= ST_WR_REQ;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_araddr  <= i_cmd_addr;
                                r_state   <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_WR_REQ: begin
                        if (r_awvalid && i_awready) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (r_wvalid && i_wready) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_aw_done && w_w_done) begin
                            r_bready      <= 1'b1;
                            r_state       <= ST_WR_RESP;
                            r_state_entry <= 1'b1;
                        end
                    end
                    ST_WR_RESP: begin
                        if (i_bvalid) begin
                            r_bready      <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_write   <= 1'b1;
                            r_rsp_data    <= '0;
                            r_rsp_resp    <= i_bresp;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= ST_RSP;
                            r_state_entry <= 1'b1;
                        end
                    end
                    ST_RD_REQ: begin
                        if (i_arready) begin
                            r_arvalid     <= 1'b0;
                            r_rready      <= 1'b1;
                            r_state       <= ST_RD_RESP;
                            r_state_entry <= 1'b1;
                        end
                    end
                    ST_RD_RESP: begin
                        if (i_rvalid) begin
                            r_rready      <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_write   <= 1'b0;
                            r_rsp_data    <= i_rdata;
                            r_rsp_resp    <= i_rresp;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= ST_RSP;
                            r_state_entry <= 1'b1;
                        end
                    end
                    ST_RSP: begin
                        if (i_rsp_ready) begin
                            r_rsp_valid   <= 1'b0;
                            r_cmd_ready   <= 1'b1;
                            r_state       <= ST_IDLE;
                            r_state_entry <= 1'b1;
                        end
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_state_entry <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_write   = r_rsp_write;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_awvalid     = r_awvalid;
    assign o_awaddr      = r_awaddr;
    assign o_wvalid      = r_wvalid;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = r_wstrb;
    assign o_bready      = r_bready;
    assign o_arvalid     = r_arvalid;
    assign o_araddr      = r_araddr;
    assign o_rready      = r_rready;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a delay-configurable AXI-Lite memory slave
// plus a register-level reference model predicting every response.
module tb_axi_lite_cmd_master;
    import axi_lite_cmd_master_pkg::*;

    localparam int RW = 36;  // {write, data[31:0], resp[1:0], timeout}

    logic        i_axi_clk;
    logic        i_axi_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic [3:0]  i_cmd_strb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_write;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_timeout;
    logic        o_awvalid;
    logic [31:0] o_awaddr;
    logic        i_awready;
    logic        o_wvalid;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_wready;
    logic        i_bvalid;
    logic        o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid;
    logic [31:0] o_araddr;
    logic        i_arready;
    logic        i_rvalid;
    logic        o_rready;
    logic [1:0]  i_rresp;
    logic [31:0] i_rdata;
    state_t      o_dbg_state;

    axi_lite_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_axi_clk(i_axi_clk), .i_axi_rst(i_axi_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_axi_clk = 1'b0;
    always #5 i_axi_clk = ~i_axi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [31:0]   ref_mem [int unsigned];
    int            last_unstable;

    // ---------------- AXI-Lite slave model ----------------
    int          cfg_aw_d = 1, cfg_w_d = 1, cfg_b_d = 1, cfg_ar_d = 1, cfg_r_d = 1;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] smem [int unsigned];
    logic [31:0] awq[$], wdq[$];
    logic [3:0]  wsq[$];
    int          aw_cnt, w_cnt, ar_cnt, aw_last, w_last, ar_last;
    int          aw_beats = 0, w_beats = 0, ar_beats = 0;
    int          b_pend, b_wait, r_wait, stable_err = 0;
    logic        r_pend;
    logic [31:0] r_addr;
    logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    function automatic logic [RW-1:0] predict(input logic w, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = ref_mem.exists(a) ? ref_mem[a] : 32'd0;
        if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
            ref_mem[a] = cur;
            return {1'b1, 32'd0, cfg_bresp, 1'b0};
        end
        return {1'b0, cur, cfg_rresp, 1'b0};
    endfunction

    task automatic slave_clear();
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        i_bresp = 0; i_rresp = 0; i_rdata = 0;
        awq.delete(); wdq.delete(); wsq.delete();
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_pend = 0; b_wait = 0; r_wait = 0; r_pend = 0;
        r_addr = 0; p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    endtask

    task automatic slave_step();
        logic hs_aw, hs_w, hs_ar, hs_b, hs_r;
        logic [31:0] a, d, cur;
        logic [3:0] s;
        if (!i_axi_rst) begin
            slave_clear();
            return;
        end
        hs_aw = p_awvalid && i_awready;
        hs_w  = p_wvalid && i_wready;
        hs_ar = p_arvalid && i_arready;
        hs_b  = i_bvalid && p_bready;
        hs_r  = i_rvalid && p_rready;
        if (p_awvalid && !hs_aw && o_awvalid && o_awaddr !== p_awaddr) stable_err++;
        if (p_wvalid && !hs_w && o_wvalid && {o_wdata, o_wstrb} !== {p_wdata, p_wstrb}) stable_err++;
        if (p_arvalid && !hs_ar && o_arvalid && o_araddr !== p_araddr) stable_err++;
        if (hs_aw) begin aw_beats++; awq.push_back(p_awaddr); aw_last = aw_cnt; end
        if (hs_w) begin w_beats++; wdq.push_back(p_wdata); wsq.push_back(p_wstrb); w_last = w_cnt; end
        if (hs_ar) begin ar_beats++; ar_last = ar_cnt; r_pend = 1; r_addr = p_araddr; r_wait = 0; end
        i_awready = 0; i_wready = 0; i_arready = 0;
        if (o_awvalid) begin aw_cnt++; i_awready = (aw_cnt >= cfg_aw_d); end else aw_cnt = 0;
        if (o_wvalid) begin w_cnt++; i_wready = (w_cnt >= cfg_w_d); end else w_cnt = 0;
        if (o_arvalid) begin ar_cnt++; i_arready = (ar_cnt >= cfg_ar_d); end else ar_cnt = 0;
        while (awq.size() > 0 && wdq.size() > 0) begin
            a = awq.pop_front(); d = wdq.pop_front(); s = wsq.pop_front();
            cur = smem.exists(a) ? smem[a] : 32'd0;
            for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
            smem[a] = cur;
            b_pend++;
        end
        if (hs_b) begin i_bvalid = 0; b_pend--; b_wait = 0; end
        if (!i_bvalid && b_pend > 0) begin
            b_wait++;
            if (b_wait >= cfg_b_d) begin i_bvalid = 1; i_bresp = cfg_bresp; end
        end
        if (hs_r) begin i_rvalid = 0; r_pend = 0; end
        if (r_pend && !i_rvalid) begin
            r_wait++;
            if (r_wait >= cfg_r_d) begin
                i_rvalid = 1; i_rresp = cfg_rresp;
                i_rdata = smem.exists(r_addr) ? smem[r_addr] : 32'd0;
            end
        end
        p_awvalid = o_awvalid; p_awaddr = o_awaddr;
        p_wvalid = o_wvalid; p_wdata = o_wdata; p_wstrb = o_wstrb;
        p_arvalid = o_arvalid; p_araddr = o_araddr;
        p_bready = o_bready; p_rready = o_rready;
    endtask

    initial begin
        slave_clear();
        forever begin
            @(negedge i_axi_clk);
            slave_step();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        cfg_aw_d = aw; cfg_w_d = w; cfg_b_d = b; cfg_ar_d = ar; cfg_r_d = r;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        n = 0;
        i_cmd_valid = 1; i_cmd_write = w; i_cmd_addr = a; i_cmd_data = d; i_cmd_strb = s;
        while (o_cmd_ready !== 1'b1 && n < 100) begin @(negedge i_axi_clk); n++; end
        if (o_cmd_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL cmd_accept: o_cmd_ready=%b after %0d cycles, required 1", o_cmd_ready, n);
            i_cmd_valid = 0;
            return;
        end
        @(negedge i_axi_clk);
        i_cmd_valid = 0;
    endtask

    task automatic get_rsp(input int hold, output logic [RW-1:0] got);
        int n;
        logic [RW-1:0] first;
        n = 0;
        got = '0;
        last_unstable = 0;
        while (o_rsp_valid !== 1'b1 && n < 400) begin @(negedge i_axi_clk); n++; end
        if (o_rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_wait: o_rsp_valid=%b after %0d cycles, required 1", o_rsp_valid, n);
            return;
        end
        first = {o_rsp_write, o_rsp_data, o_rsp_resp, o_rsp_timeout};
        for (int i = 0; i < hold; i++) begin
            @(negedge i_axi_clk);
            if ({o_rsp_write, o_rsp_data, o_rsp_resp, o_rsp_timeout} !== first ||
                o_rsp_valid !== 1'b1 || o_cmd_ready !== 1'b0) last_unstable++;
        end
        got = {o_rsp_write, o_rsp_data, o_rsp_resp, o_rsp_timeout};
        i_rsp_ready = 1;
        @(negedge i_axi_clk);
        i_rsp_ready = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_axi_rst = 0;
        repeat (3) @(negedge i_axi_clk);
        checks++;
        if ({o_cmd_ready, o_rsp_valid, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
             o_awaddr, o_araddr, o_wdata, o_wstrb, o_rsp_data, o_rsp_resp, o_rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b aw=%b w=%b b=%b ar=%b r=%b, required all 0",
                     o_cmd_ready, o_rsp_valid, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready);
        end
        i_axi_rst = 1;
        @(negedge i_axi_clk);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b state=%0d, required 1 / IDLE", o_cmd_ready, o_dbg_state);
        end
    endtask

    task automatic test_write_through();
        logic [RW-1:0] got, exp;
        set_delays(1, 1, 1, 1, 1);
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
        exp_q.push_back(predict(1'b1, 32'h04, 32'h0000_000A, 4'hF));
        send_cmd(1'b1, 32'h04, 32'h0000_000A, 4'hF);
        checks++;
        if ({o_awvalid, o_wvalid, o_cmd_ready, o_awaddr, o_wdata, o_wstrb} !==
            {1'b1, 1'b1, 1'b0, 32'h04, 32'h0000_000A, 4'hF}) begin
            errors++;
            $display("FAIL wr_latency: awvalid=%b wvalid=%b awaddr=%h wdata=%h, required 1 1 00000004 0000000a",
                     o_awvalid, o_wvalid, o_awaddr, o_wdata);
        end
        get_rsp(0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wr_rsp: got %h, required %h", got, exp);
        end
        exp_q.push_back(predict(1'b0, 32'h04, 32'h0, 4'h0));
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0);
        get_rsp(0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rd_back: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_stalled_read();
        logic [RW-1:0] got, exp;
        int se;
        smem[32'h10] = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        set_delays(1, 1, 1, 5, 3);
        se = stable_err;
        exp_q.push_back(predict(1'b0, 32'h10, 32'h0, 4'h0));
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        get_rsp(0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_rd_rsp: got %h, required %h", got, exp);
        end
        checks++;
        if (ar_last !== 5 || stable_err !== se) begin
            errors++;
            $display("FAIL stall_arvalid: arvalid cycles=%0d addr changes=%0d, required 5 / 0",
                     ar_last, stable_err - se);
        end
        set_delays(1, 1, 1, 1, 1);
    endtask

    task automatic test_skewed_write();
        logic [RW-1:0] got, exp;
        int awb, wb, awd, wd;
        for (int k = 0; k < 2; k++) begin
            awd = (k == 0) ? 5 : 1;
            wd  = (k == 0) ? 1 : 5;
            set_delays(awd, wd, 2, 1, 1);
            awb = aw_beats; wb = w_beats;
            exp_q.push_back(predict(1'b1, 32'h20 + 32'(k * 4), 32'h1234_0000 + 32'(k), 4'hF));
            send_cmd(1'b1, 32'h20 + 32'(k * 4), 32'h1234_0000 + 32'(k), 4'hF);
            get_rsp(0, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL skew_rsp[%0d]: got %h, required %h", k, got, exp);
            end
            checks++;
            if (aw_beats - awb !== 1 || w_beats - wb !== 1 || aw_last !== awd || w_last !== wd) begin
                errors++;
                $display("FAIL skew_beats[%0d]: aw beats=%0d w beats=%0d aw cycles=%0d w cycles=%0d, required 1 1 %0d %0d",
                         k, aw_beats - awb, w_beats - wb, aw_last, w_last, awd, wd);
            end
        end
        set_delays(1, 1, 1, 1, 1);
    endtask

    task automatic test_timeout();
        logic [RW-1:0] got, exp;
        int bcnt, n;
        set_delays(1, 1, 1000, 1, 1);
        void'(predict(1'b1, 32'h08, 32'h0000_0055, 4'hF));
        exp_q.push_back({1'b1, 32'd0, RESP_SLVERR, 1'b1});
        send_cmd(1'b1, 32'h08, 32'h0000_0055, 4'hF);
        bcnt = 0; n = 0;
        while (o_rsp_valid !== 1'b1 && n < 100) begin
            if (o_bready === 1'b1) bcnt++;
            @(negedge i_axi_clk);
            n++;
        end
        checks++;
        if (bcnt !== 16) begin
            errors++;
            $display("FAIL timeout_bready: bready high %0d cycles, required 16", bcnt);
        end
        get_rsp(0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL timeout_rsp: got %h, required %h", got, exp);
        end
        b_pend = 0; b_wait = 0;
        set_delays(1, 1, 1, 1, 1);
        exp_q.push_back(predict(1'b0, 32'h08, 32'h0, 4'h0));
        send_cmd(1'b0, 32'h08, 32'h0, 4'h0);
        get_rsp(0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL after_timeout_rd: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_backpressure_reset();
        logic [RW-1:0] got, exp;
        int n, saw;
        set_delays(1, 1, 1, 2, 2);
        exp_q.push_back(predict(1'b0, 32'h10, 32'h0, 4'h0));
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        get_rsp(10, got);
        exp = exp_q.pop_front();
        checks++;
        if (last_unstable !== 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable cycles during hold, required 0", last_unstable);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL bp_rsp: got %h, required %h", got, exp);
        end
        set_delays(1, 1, 1, 1, 1000);
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0);
        n = 0;
        while (o_rready !== 1'b1 && n < 50) begin @(negedge i_axi_clk); n++; end
        checks++;
        if (o_rready !== 1'b1 || o_dbg_state !== ST_RD_RESP) begin
            errors++;
            $display("FAIL rst_reach_rd_resp: rready=%b state=%0d, required 1 / RD_RESP", o_rready, o_dbg_state);
        end
        i_axi_rst = 0;
        @(negedge i_axi_clk);
        checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid, o_cmd_ready} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_valids: aw=%b w=%b b=%b ar=%b r=%b rsp=%b cmd_ready=%b, required all 0",
                     o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid, o_cmd_ready);
        end
        @(negedge i_axi_clk);
        i_axi_rst = 1;
        set_delays(1, 1, 1, 1, 1);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_axi_clk);
            if (o_rsp_valid !== 1'b0) saw++;
        end
        checks++;
        if (saw !== 0 || o_cmd_ready !== 1'b1 || o_dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_recover: rsp cycles=%0d cmd_ready=%b state=%0d, required 0 / 1 / IDLE",
                     saw, o_cmd_ready, o_dbg_state);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [RW-1:0] got, exp;
        logic w;
        logic [31:0] a, d;
        logic [3:0] s;
        int awb, wb, nwr;
        awb = aw_beats; wb = w_beats; nwr = 0;
        for (int i = 0; i < 40; i++) begin
            set_delays($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
                       $urandom_range(1, 6), $urandom_range(1, 6));
            cfg_bresp = 2'($urandom_range(0, 3));
            cfg_rresp = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7) * 4);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (w) nwr++;
            exp_q.push_back(predict(w, a, d, s));
            send_cmd(w, a, d, s);
            get_rsp($urandom_range(0, 3), got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: write=%b addr=%h got %h, required %h", i, w, a, got, exp);
            end
        end
        checks++;
        if (aw_beats - awb !== nwr || w_beats - wb !== nwr) begin
            errors++;
            $display("FAIL rand_beats: aw=%0d w=%0d, required %0d each", aw_beats - awb, w_beats - wb, nwr);
        end
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        i_axi_rst = 0; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0;
        i_cmd_data = 0; i_cmd_strb = 0; i_rsp_ready = 0;
        @(negedge i_axi_clk);
        test_reset();
        test_write_through();
        test_stalled_read();
        test_skewed_write();
        test_timeout();
        test_backpressure_reset();
        test_back_to_back_random();
        repeat (2) @(negedge i_axi_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Command-to-AXI-Lite bridge that sits directly upstream of the lightshow register slave and drives its AXI-Lite slave port.
- Accepts one register command at a time (read or write) on a simple valid/ready stream.
- Runs the full AXI-Lite transaction and returns data/response on a second valid/ready stream.
- Used by test benches and by the on-chip sequencer to program the LED controller.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width.
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 256, cycles allowed per bus phase before abort; 0 disables the timeout.

Ports:
- i_axi_clk  in  1  single clock for all logic.
- i_axi_rst  in  1  synchronous reset, active-low.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_WIDTH  register byte address.
- i_cmd_data  in  DATA_WIDTH  write data.
- i_cmd_strb  in  STROBE_WIDTH  write strobes.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed.
- o_rsp_write  out  1  echoes the command type.
- o_rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- o_rsp_resp  out  2  BRESP/RRESP captured from the slave.
- o_rsp_timeout  out  1  phase timed out.
- o_awvalid  out  1  write address valid.
- o_awaddr  out  ADDR_WIDTH  write address.
- i_awready  in  1  write address ready.
- o_wvalid  out  1  write data valid.
- o_wdata  out  DATA_WIDTH  write data.
- o_wstrb  out  STROBE_WIDTH  write strobes.
- i_wready  in  1  write data ready.
- i_bvalid  in  1  write response valid.
- o_bready  out  1  write response ready.
- i_bresp  in  2  write response.
- o_arvalid  out  1  read address valid.
- o_araddr  out  ADDR_WIDTH  read address.
- i_arready  in  1  read address ready.
- i_rvalid  in  1  read data valid.
- o_rready  out  1  read data ready.
- i_rresp  in  2  read response.
- i_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (i_axi_rst low at a clock edge): FSM goes to IDLE. All valid/ready outputs are 0. o_cmd_ready is 0 during reset, then 1 in IDLE. All address/data/response outputs are 0. Reset mid-transaction abandons it with no response.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid, register addr/data/strb/write.
  - Next cycle: write -> WR_REQ; read -> RD_REQ.
  - Command-to-AWVALID/ARVALID latency is 1 cycle.
- WR_REQ:
  - Assert o_awvalid and o_wvalid together.
  - Each valid drops independently the cycle after its own ready handshake (aw_done, w_done flags). AW and W may complete in either order or the same cycle.
  - When both are done -> WR_RESP.
- WR_RESP: o_bready = 1. On i_bvalid, capture i_bresp -> RSP.
- RD_REQ: o_arvalid = 1. On i_arready -> RD_RESP.
- RD_RESP: o_rready = 1. On i_rvalid, capture i_rdata and i_rresp -> RSP.
- RSP:
  - o_rsp_valid = 1; outputs hold stable until i_rsp_ready.
  - Then -> IDLE, with o_cmd_ready = 1 on the following cycle.
  - No command is accepted while a transaction or response is pending (single outstanding).
- Address/data outputs are stable while their valid is high; AXI valids never drop before ready, except on timeout.
- Timeout:
  - A phase counter clears on every state entry and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When count == TIMEOUT_CYCLES-1 without completion: deassert all AXI valid/ready next cycle, go to RSP with o_rsp_timeout = 1, o_rsp_resp = 2'b10 (SLVERR), o_rsp_data = 0.
  - The counter is wide enough for TIMEOUT_CYCLES and never wraps.
  - A handshake in the same cycle as the terminal count wins; no timeout is reported.
- o_rsp_data is 0 for writes; o_rsp_timeout is 0 on normal completion.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - AXI response constants: OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3.
- The phase timeout counter is a natural sub-module: phase_timer. Inputs: clear, enable. Output: expired. Counting disabled when TIMEOUT_CYCLES = 0.
- The remainder is a single FSM module.

Test Plan:
- Write through to lightshow: cmd write addr 0x04, data 0x0000000A, strb 0xF -> AWVALID/WVALID rise 1 cycle after accept. Response: write = 1, resp = 0, timeout = 0. A following read of 0x04 returns 0x0000000A.
- Read with stalled slave: RREADY/ARREADY stub delays ARREADY 5 cycles and RVALID 3 cycles, rdata 0xDEADBEEF -> ARVALID held 5 cycles with stable addr; response data 0xDEADBEEF, resp 0.
- Skewed AW/W ready: WREADY 4 cycles before AWREADY, then the reverse -> WVALID drops after its own handshake; exactly one AW and one W beat per command; both cases complete with resp 0.
- Timeout: slave never asserts BVALID, TIMEOUT_CYCLES = 16 -> BREADY drops 16 cycles after WR_RESP entry; response timeout = 1, resp = 2, data = 0. The next command is accepted normally.
- Backpressure and reset: hold i_rsp_ready = 0 for 10 cycles -> rsp fields stable and o_cmd_ready = 0. Then pull i_axi_rst low in RD_RESP -> all valids 0 next cycle, no response emitted, IDLE after release.
